// File: rtl/julia_pixel_sequencer_pkg.sv
// Shared types and constants for the Julia pixel sequencer.
package julia_pixel_sequencer_pkg;

  localparam int unsigned COORD_W     = 32;
  localparam int unsigned COLOR_W     = 16;
  localparam int unsigned Q_FRAC_BITS = 24;

  localparam logic [COLOR_W-1:0] DEFAULT_TIMEOUT_COLOR = 16'hF800;

  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_LOAD    = 3'd1,
    SEQ_RUN     = 3'd2,
    SEQ_WRITE   = 3'd3,
    SEQ_ADVANCE = 3'd4,
    SEQ_DONE    = 3'd5
  } seq_state_t;

  // Viewport values that must survive the whole frame.
  typedef struct packed {
    logic [COORD_W-1:0] x_min;
    logic [COORD_W-1:0] step_x;
    logic [COORD_W-1:0] step_y;
  } vp_latch_t;

endpackage

// File: rtl/julia_pixel_sequencer_if.sv
// Frame-buffer write port: valid/ready handshake carrying address and colour.
interface julia_pixel_sequencer_if #(
  parameter int unsigned ADDR_W = 17
);
  logic              fb_valid;
  logic              fb_ready;
  logic [ADDR_W-1:0] fb_addr;
  logic [15:0]       fb_data;

  modport master (output fb_valid, output fb_addr, output fb_data, input  fb_ready);
  modport slave  (input  fb_valid, input  fb_addr, input  fb_data, output fb_ready);
endinterface

// File: rtl/julia_pixel_sequencer_raster_counter.sv
// Raster position tracker: column/line counters plus linear frame-buffer address.
module julia_pixel_sequencer_raster_counter #(
  parameter int unsigned H_RES  = 320,
  parameter int unsigned V_RES  = 240,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last_col_c,
  output logic              last_row_c
);

  localparam int unsigned PX_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned PY_W = (V_RES > 1) ? $clog2(V_RES) : 1;

  logic [PX_W-1:0] px;
  logic [PY_W-1:0] py;

  assign last_col_c = (px == PX_W'(H_RES - 1));
  assign last_row_c = (py == PY_W'(V_RES - 1));

  // Address advances every pixel; it never needs a multiply because it tracks px/py.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      px   <= '0;
      py   <= '0;
      addr <= '0;
    end else if (step) begin
      addr <= addr + ADDR_W'(1);
      if (!last_col_c) begin
        px <= px + PX_W'(1);
      end else begin
        px <= '0;
        if (!last_row_c) py <= py + PY_W'(1);
      end
    end
  end

endmodule

// File: rtl/julia_pixel_sequencer.sv
// Frame-level initiator: walks the raster, runs the Julia engine per pixel and
// writes each returned colour to the frame buffer.
module julia_pixel_sequencer
  import julia_pixel_sequencer_pkg::*;
#(
  parameter int unsigned         H_RES         = 320,
  parameter int unsigned         V_RES         = 240,
  parameter int unsigned         ADDR_W        = 17,
  parameter int unsigned         LOAD_CYCLES   = 2,
  parameter int unsigned         WDOG_MAX      = 65535,
  parameter logic [COLOR_W-1:0]  TIMEOUT_COLOR = DEFAULT_TIMEOUT_COLOR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] x_min,
  input  logic [COORD_W-1:0] y_min,
  input  logic [COORD_W-1:0] step_x,
  input  logic [COORD_W-1:0] step_y,
  output logic               calc_enable,
  output logic [COORD_W-1:0] x0,
  output logic [COORD_W-1:0] y0,
  input  logic               calc_end,
  input  logic [COLOR_W-1:0] color_in,
  julia_pixel_sequencer_if.master fb,
  output logic               busy,
  output logic               frame_done
);

  localparam int unsigned LC_W   = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam int unsigned WDOG_W = $clog2(WDOG_MAX + 1);

  seq_state_t        state;
  vp_latch_t         vp_q;
  logic [LC_W-1:0]   load_cnt;
  logic [WDOG_W-1:0] wdog;
  logic              clear_c;
  logic              step_c;
  logic              last_col_c;
  logic              last_row_c;

  assign clear_c = (state == SEQ_IDLE) && start;
  assign step_c  = (state == SEQ_ADVANCE);

  julia_pixel_sequencer_raster_counter #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_raster (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear_c),
    .step       (step_c),
    .addr       (fb.fb_addr),
    .last_col_c (last_col_c),
    .last_row_c (last_row_c)
  );

  // Sequencer FSM; calc_enable is high exactly while in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SEQ_IDLE;
      vp_q        <= '0;
      load_cnt    <= '0;
      wdog        <= '0;
      calc_enable <= 1'b0;
      x0          <= '0;
      y0          <= '0;
      fb.fb_valid <= 1'b0;
      fb.fb_data  <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        SEQ_IDLE: begin
          if (start) begin
            vp_q     <= '{x_min: x_min, step_x: step_x, step_y: step_y};
            x0       <= x_min;
            y0       <= y_min;
            busy     <= 1'b1;
            load_cnt <= '0;
            state    <= SEQ_LOAD;
          end
        end
        SEQ_LOAD: begin
          if (load_cnt == LC_W'(LOAD_CYCLES - 1)) begin
            load_cnt    <= '0;
            calc_enable <= 1'b1;
            state       <= SEQ_RUN;
          end else begin
            load_cnt <= load_cnt + LC_W'(1);
          end
        end
        SEQ_RUN: begin
          wdog <= wdog + WDOG_W'(1);
          // A finished engine wins over a watchdog expiring in the same cycle.
          if (calc_end) begin
            fb.fb_data  <= color_in;
            fb.fb_valid <= 1'b1;
            calc_enable <= 1'b0;
            state       <= SEQ_WRITE;
          end else if (wdog == WDOG_W'(WDOG_MAX)) begin
            fb.fb_data  <= TIMEOUT_COLOR;
            fb.fb_valid <= 1'b1;
            calc_enable <= 1'b0;
            state       <= SEQ_WRITE;
          end
        end
        SEQ_WRITE: begin
          if (fb.fb_ready) begin
            fb.fb_valid <= 1'b0;
            state       <= SEQ_ADVANCE;
          end
        end
        SEQ_ADVANCE: begin
          wdog <= '0;
          if (!last_col_c) begin
            x0    <= x0 + vp_q.step_x;
            state <= SEQ_LOAD;
          end else if (!last_row_c) begin
            x0    <= vp_q.x_min;
            y0    <= y0 + vp_q.step_y;
            state <= SEQ_LOAD;
          end else begin
            busy       <= 1'b0;
            frame_done <= 1'b1;
            state      <= SEQ_DONE;
          end
        end
        SEQ_DONE: begin
          state <= SEQ_IDLE;
        end
        default: begin
          state <= SEQ_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_julia_pixel_sequencer.sv
// Directed self-checking bench for julia_pixel_sequencer on a 4x2 raster.
module tb_julia_pixel_sequencer;

  localparam int unsigned H_RES       = 4;
  localparam int unsigned V_RES       = 2;
  localparam int unsigned ADDR_W      = 3;
  localparam int unsigned LOAD_CYCLES = 2;
  localparam int unsigned WDOG_MAX    = 15;
  localparam int          NPIX        = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] x_min = '0, y_min = '0, step_x = '0, step_y = '0;
  logic        calc_enable;
  logic [31:0] x0, y0;
  logic        calc_end;
  logic [15:0] color_in;
  logic        busy, frame_done;
  logic        fb_ready = 1'b1;

  julia_pixel_sequencer_if #(.ADDR_W(ADDR_W)) fb ();
  assign fb.fb_ready = fb_ready;

  julia_pixel_sequencer #(
    .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W),
    .LOAD_CYCLES(LOAD_CYCLES), .WDOG_MAX(WDOG_MAX), .TIMEOUT_COLOR(16'hF800)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .x_min(x_min), .y_min(y_min), .step_x(step_x), .step_y(step_y),
    .calc_enable(calc_enable), .x0(x0), .y0(y0),
    .calc_end(calc_end), .color_in(color_in),
    .fb(fb), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Engine stub: calc_end rises 3 cycles after enable rises, sticky until enable falls.
  int eng_cnt;
  bit eng_never = 1'b0;
  always @(posedge clk) begin
    if (rst || !calc_enable) begin
      eng_cnt  <= 0;
      calc_end <= 1'b0;
    end else begin
      eng_cnt <= eng_cnt + 1;
      if (!eng_never && eng_cnt == 2) calc_end <= 1'b1;
    end
  end
  assign color_in = 16'(fb.fb_addr);

  // Observation monitor sampled on the falling edge.
  logic [ADDR_W-1:0] wr_addr[$];
  logic [15:0]       wr_data[$];
  logic [31:0]       rise_x[$], rise_y[$];
  int                gap_q[$], hi_q[$];
  int                fd_count = 0;
  int                low_cnt = 0, hi_cnt = 0;
  bit                prev_en = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_en = 1'b0; low_cnt = 0; hi_cnt = 0;
    end else begin
      if (fb.fb_valid && fb_ready) begin
        wr_addr.push_back(fb.fb_addr);
        wr_data.push_back(fb.fb_data);
      end
      if (frame_done) fd_count++;
      if (calc_enable) begin
        if (!prev_en) begin
          rise_x.push_back(x0); rise_y.push_back(y0); gap_q.push_back(low_cnt);
        end
        hi_cnt++; low_cnt = 0;
      end else begin
        if (prev_en) begin hi_q.push_back(hi_cnt); hi_cnt = 0; end
        if (busy) low_cnt++; else low_cnt = 0;
      end
      prev_en = calc_enable;
    end
  end

  task automatic clear_obs();
    wr_addr.delete(); wr_data.delete(); rise_x.delete(); rise_y.delete();
    gap_q.delete(); hi_q.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (frame_done) ok = 1'b1;
    end
  endtask

  task automatic wait_addr(input int a, input bit need_en, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (busy && int'(fb.fb_addr) == a && (!need_en || calc_enable)) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (calc_enable !== 1'b0) begin errors++; $display("FAIL reset_calc_enable got %b want 0", calc_enable); end
    checks++; if (x0 !== 32'h0 || y0 !== 32'h0) begin errors++; $display("FAIL reset_xy got %h/%h want 0/0", x0, y0); end
    checks++; if (fb.fb_valid !== 1'b0) begin errors++; $display("FAIL reset_fb_valid got %b want 0", fb.fb_valid); end
    checks++; if (fb.fb_addr !== '0 || fb.fb_data !== 16'h0) begin errors++; $display("FAIL reset_fb_bus got %h/%h want 0/0", fb.fb_addr, fb.fb_data); end
    checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL reset_status got %b%b want 00", busy, frame_done); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    bit ok; int fd0;
    @(posedge clk); #1 clear_obs(); fd0 = fd_count; eng_never = 1'b0; fb_ready = 1'b1;
    pulse_start();
    wait_done(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got no frame_done want frame_done"); end
    repeat (2) @(posedge clk); #1;
    checks++; if (wr_addr.size() != NPIX) begin errors++; $display("FAIL basic_write_count got %0d want %0d", wr_addr.size(), NPIX); end
    for (int i = 0; i < NPIX && i < wr_addr.size(); i++) begin
      checks++; if (int'(wr_addr[i]) != i || wr_data[i] !== 16'(i)) begin
        errors++; $display("FAIL basic_write%0d got addr %0d data %h want addr %0d data %h", i, wr_addr[i], wr_data[i], i, 16'(i));
      end
    end
    checks++; if (fd_count - fd0 != 1) begin errors++; $display("FAIL basic_frame_done got %0d pulses want 1", fd_count - fd0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", busy); end
    checks++; if (hi_q.size() < 1 || hi_q[0] != 4) begin errors++; $display("FAIL basic_run_len got %0d want 4", hi_q.size() > 0 ? hi_q[0] : -1); end
  endtask

  task automatic test_coords();
    bit ok;
    @(posedge clk); #1 clear_obs();
    x_min = 32'hFE000000; step_x = 32'h00100000; y_min = 32'h01000000; step_y = 32'hFFF00000;
    pulse_start();
    // Viewport inputs are free to move once the frame is latched.
    x_min = 32'h12345678; step_x = 32'h0; y_min = 32'h0; step_y = 32'h0;
    wait_done(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL coords_timeout got no frame_done want frame_done"); end
    repeat (2) @(posedge clk); #1;
    checks++; if (rise_x.size() != NPIX) begin errors++; $display("FAIL coords_pixels got %0d want %0d", rise_x.size(), NPIX); end
    if (rise_x.size() == NPIX) begin
      checks++; if (rise_x[0] !== 32'hFE000000 || rise_y[0] !== 32'h01000000) begin errors++; $display("FAIL coords_p00 got %h/%h want fe000000/01000000", rise_x[0], rise_y[0]); end
      checks++; if (rise_x[1] !== 32'hFE100000) begin errors++; $display("FAIL coords_p10 got %h want fe100000", rise_x[1]); end
      checks++; if (rise_x[4] !== 32'hFE000000 || rise_y[4] !== 32'h00F00000) begin errors++; $display("FAIL coords_p01 got %h/%h want fe000000/00f00000", rise_x[4], rise_y[4]); end
      checks++; if (rise_x[7] !== 32'hFE300000 || rise_y[7] !== 32'h00F00000) begin errors++; $display("FAIL coords_p31 got %h/%h want fe300000/00f00000", rise_x[7], rise_y[7]); end
      // First pixel: LOAD only; later pixels add the write and advance cycles.
      for (int i = 0; i < NPIX; i++) begin
        checks++; if (gap_q[i] != ((i == 0) ? 2 : 4)) begin errors++; $display("FAIL coords_enable_low%0d got %0d want %0d", i, gap_q[i], (i == 0) ? 2 : 4); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok; int n2;
    @(posedge clk); #1 clear_obs(); fb_ready = 1'b1;
    pulse_start();
    wait_addr(2, 1'b0, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_reach_pixel2 got timeout want addr 2"); end
    @(posedge clk); #1 fb_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); if (fb.fb_valid) ok = 1'b1; end
    checks++; if (!ok) begin errors++; $display("FAIL bp_valid_rise got timeout want fb_valid"); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (fb.fb_valid !== 1'b1 || fb.fb_addr !== 3'd2 || fb.fb_data !== 16'h0002 || calc_enable !== 1'b0) begin
        errors++; $display("FAIL bp_stall%0d got v%b a%0d d%h en%b want v1 a2 d0002 en0", i, fb.fb_valid, fb.fb_addr, fb.fb_data, calc_enable);
      end
      @(negedge clk);
    end
    fb_ready = 1'b1;
    wait_done(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got no frame_done want frame_done"); end
    repeat (2) @(posedge clk); #1;
    n2 = 0;
    foreach (wr_addr[i]) if (wr_addr[i] == 3'd2) n2++;
    checks++; if (n2 != 1 || wr_addr.size() != NPIX) begin errors++; $display("FAIL bp_writes got %0d addr2 writes of %0d want 1 of %0d", n2, wr_addr.size(), NPIX); end
  endtask

  task automatic test_watchdog();
    bit ok;
    @(posedge clk); #1 clear_obs(); eng_never = 1'b1;
    pulse_start();
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wdog_timeout got no frame_done want frame_done"); end
    repeat (2) @(posedge clk); #1 eng_never = 1'b0;
    checks++; if (wr_addr.size() != NPIX || hi_q.size() != NPIX) begin errors++; $display("FAIL wdog_counts got %0d/%0d want %0d", wr_addr.size(), hi_q.size(), NPIX); end
    for (int i = 0; i < NPIX && i < wr_addr.size() && i < hi_q.size(); i++) begin
      checks++; if (int'(wr_addr[i]) != i || wr_data[i] !== 16'hF800 || hi_q[i] != 16) begin
        errors++; $display("FAIL wdog_pixel%0d got addr %0d data %h run %0d want addr %0d data f800 run 16", i, wr_addr[i], wr_data[i], hi_q[i], i);
      end
    end
  endtask

  task automatic test_start_ignore();
    bit ok; int fd0;
    @(posedge clk); #1 clear_obs(); fd0 = fd_count;
    pulse_start();
    wait_addr(3, 1'b0, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ign_reach_pixel3 got timeout want addr 3"); end
    pulse_start();
    wait_done(1000, ok);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL ign_timeout got no frame_done want frame_done"); end
    repeat (5) @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_done_start got busy %b want 0", busy); end
    checks++; if (wr_addr.size() != NPIX || fd_count - fd0 != 1) begin errors++; $display("FAIL ign_frame got %0d writes %0d done want %0d writes 1 done", wr_addr.size(), fd_count - fd0, NPIX); end
    if (wr_addr.size() == NPIX) begin
      checks++; if (wr_addr[4] !== 3'd4 || wr_addr[7] !== 3'd7) begin errors++; $display("FAIL ign_sequence got %0d,%0d want 4,7", wr_addr[4], wr_addr[7]); end
    end
    clear_obs();
    pulse_start();
    wait_done(1000, ok);
    repeat (2) @(posedge clk); #1;
    checks++; if (!ok || wr_addr.size() != NPIX || wr_addr[0] !== 3'd0) begin errors++; $display("FAIL ign_fresh_frame got ok %b writes %0d want ok 1 writes %0d from addr 0", ok, wr_addr.size(), NPIX); end
  endtask

  task automatic test_reset_mid();
    bit ok; int fd0;
    @(posedge clk); #1 clear_obs(); fd0 = fd_count;
    pulse_start();
    wait_addr(5, 1'b1, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_reach_run5 got timeout want run of pixel 5"); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (calc_enable !== 1'b0 || busy !== 1'b0 || fb.fb_valid !== 1'b0 || fb.fb_addr !== '0 || fb.fb_data !== 16'h0 || x0 !== 32'h0 || y0 !== 32'h0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs got en%b busy%b v%b a%0d d%h x%h y%h fd%b want all 0", calc_enable, busy, fb.fb_valid, fb.fb_addr, fb.fb_data, x0, y0, frame_done);
    end
    repeat (20) @(posedge clk); #1;
    checks++; if (fd_count != fd0 || wr_addr.size() != 5) begin errors++; $display("FAIL rstmid_abandon got %0d done %0d writes want 0 done 5 writes", fd_count - fd0, wr_addr.size()); end
    clear_obs();
    pulse_start();
    wait_done(1000, ok);
    repeat (2) @(posedge clk); #1;
    checks++; if (!ok || wr_addr.size() != NPIX || wr_addr[0] !== 3'd0) begin errors++; $display("FAIL rstmid_restart got ok %b writes %0d want ok 1 writes %0d from addr 0", ok, wr_addr.size(), NPIX); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_coords();
    test_backpressure();
    test_watchdog();
    test_start_ignore();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
